// File: rtl/fb_write_queue_if.sv
// ============================================================================
//  Module      : fb_write_queue_if
//  Description : Pixel, clear and vmem-port bundle for fb_write_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fb_write_queue_if #(
  parameter int ADDR_W = 19,
  parameter int CNT_W  = 5
);
  logic [15:0]       px_x;
  logic [15:0]       px_y;
  logic              px_we;
  logic              px_ready;
  logic              video_on;
  logic              clear_start;
  logic              clear_busy;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_din;
  logic [CNT_W-1:0]  fifo_count;
  logic [15:0]       clip_count;

  modport master (
    output px_x, px_y, px_we, video_on, clear_start,
    input  px_ready, clear_busy, mem_we, mem_addr, mem_din, fifo_count, clip_count
  );

  modport slave (
    input  px_x, px_y, px_we, video_on, clear_start,
    output px_ready, clear_busy, mem_we, mem_addr, mem_din, fifo_count, clip_count
  );
endinterface

`default_nettype wire

// File: rtl/fb_write_queue.sv
// ============================================================================
//  Module      : fb_write_queue
//  Description : Clips and queues accelerator pixels, drains them into the
//                1-bit framebuffer during blanking, and runs full-frame clears.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_write_queue #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 19
) (
  input  wire logic          clk,
  input  wire logic          reset,
  fb_write_queue_if.slave    bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] C_CLR_LAST = ADDR_W'(H_RES * V_RES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_s1_valid;
  logic              r_s1_in;
  logic [15:0]       r_s1_x;
  logic [15:0]       r_s1_y;
  logic [ADDR_W-1:0] r_fifo [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_clear_pend;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_din;
  logic [15:0]       r_clip;

  logic              w_ready;
  logic              w_accept;
  logic              w_in_range;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_can_clear;
  logic [ADDR_W-1:0] w_s1_addr;

  // Two-slot margin: one entry may still be in stage 1 when ready is sampled.
  assign w_ready     = (r_count <= CNT_W'(DEPTH - 2)) && (r_state != S_CLEAR) && !r_clear_pend;
  assign w_accept    = bus.px_we && w_ready;
  assign w_in_range  = (bus.px_x < 16'(H_RES)) && (bus.px_y < 16'(V_RES));
  assign w_s1_addr   = ADDR_W'(r_s1_x) + ADDR_W'(r_s1_y) * ADDR_W'(H_RES);
  assign w_push      = r_s1_valid && r_s1_in;
  assign w_empty     = (r_count == '0);
  assign w_can_clear = r_clear_pend && w_empty && !r_s1_valid;
  // IDLE pops too, so a pixel reaches vmem two edges after acceptance.
  assign w_pop       = !w_empty && !bus.video_on && (r_state != S_CLEAR);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_s1_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_in    <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_clip     <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_x  <= bus.px_x;
        r_s1_y  <= bus.px_y;
        r_s1_in <= w_in_range;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (r_s1_valid && !r_s1_in && (r_clip != 16'hFFFF)) begin
        r_clip <= r_clip + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_clear_pend <= 1'b0;
      r_clr_cnt    <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      if (bus.clear_start && !r_clear_pend && (r_state != S_CLEAR)) begin
        r_clear_pend <= 1'b1;
      end
      if (w_pop) begin
        r_mem_we   <= 1'b1;
        r_mem_addr <= r_fifo[r_rd_ptr];
        r_mem_din  <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_can_clear) begin
            r_state      <= S_CLEAR;
            r_clear_pend <= 1'b0;
          end else if (!w_empty) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_empty) begin
            r_state <= S_IDLE;
          end
        end
        S_CLEAR: begin
          if (!bus.video_on) begin
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_clr_cnt;
            r_mem_din  <= 1'b0;
            if (r_clr_cnt == C_CLR_LAST) begin
              r_clr_cnt <= '0;
              r_state   <= S_IDLE;
            end else begin
              r_clr_cnt <= r_clr_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.px_ready   = w_ready;
  assign bus.clear_busy = r_clear_pend || (r_state == S_CLEAR);
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_din    = r_mem_din;
  assign bus.fifo_count = r_count;
  assign bus.clip_count = r_clip;

endmodule

`default_nettype wire
